// File: rtl/isp_ycbcr_binarize.sv
// RGB565 -> Cb/Cr threshold mask with delay-matched sync/pixel forwarding (4-cycle pipeline).
// Optional previous-frame foreground pixel counter enabled by defining ISP_BIN_PIX_CNT_EN.
module isp_ycbcr_binarize #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 20
) (
  input  logic             vtc_clk,
  input  logic             vtc_rstn,
  input  logic             pre_hs,
  input  logic             pre_vs,
  input  logic             pre_wr_en,
  input  logic [15:0]      pre_rgb565,
  input  logic [7:0]       cb_min,
  input  logic [7:0]       cb_max,
  input  logic [7:0]       cr_min,
  input  logic [7:0]       cr_max,
  output logic             isp_href,
  output logic             isp_vsync,
  output logic             isp_wr_en,
  output logic             isp_1bit_out,
  output logic [15:0]      syn_data,
  output logic [CNT_W-1:0] fg_count,
  output logic             fg_count_vld
);

  function automatic logic in_rng(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  logic        r_vs_d;
  logic        w_vs_rise;
  logic [7:0]  r_cb_min_s, r_cb_max_s, r_cr_min_s, r_cr_max_s;
  logic [18:0] r_ctl_sr [LATENCY];
  logic [31:0] r_thr_p1, r_thr_p2, r_thr_p3;
  logic [7:0]  r_r8_p1, r_g8_p1, r_b8_p1;
  logic [15:0] r_r43_p2, r_g85_p2, r_b128_p2, r_r128_p2, r_g107_p2, r_b21_p2;
  logic [7:0]  r_cb_p3, r_cr_p3;
  logic        r_mask_p4;

  assign w_vs_rise = pre_vs & ~r_vs_d;

  // Shadows reload only at frame start so a frame is binarized with one threshold set
  always_ff @(posedge vtc_clk or negedge vtc_rstn) begin
    if (!vtc_rstn) begin
      r_vs_d     <= 1'b0;
      r_cb_min_s <= 8'd77;
      r_cb_max_s <= 8'd127;
      r_cr_min_s <= 8'd133;
      r_cr_max_s <= 8'd173;
    end else begin
      r_vs_d <= pre_vs;
      if (w_vs_rise) begin
        r_cb_min_s <= cb_min;
        r_cb_max_s <= cb_max;
        r_cr_min_s <= cr_min;
        r_cr_max_s <= cr_max;
      end
    end
  end

  always_ff @(posedge vtc_clk or negedge vtc_rstn) begin
    if (!vtc_rstn) begin
      for (int i = 0; i < LATENCY; i++) r_ctl_sr[i] <= '0;
    end else begin
      r_ctl_sr[0] <= {pre_hs, pre_vs, pre_wr_en, pre_rgb565};
      for (int i = 1; i < LATENCY; i++) r_ctl_sr[i] <= r_ctl_sr[i-1];
    end
  end

  // Thresholds ride with the pixel, so a pixel coincident with the vsync edge keeps the old set
  always_ff @(posedge vtc_clk or negedge vtc_rstn) begin
    if (!vtc_rstn) begin
      r_thr_p1  <= '0;
      r_r8_p1   <= '0;
      r_g8_p1   <= '0;
      r_b8_p1   <= '0;
      r_thr_p2  <= '0;
      r_r43_p2  <= '0;
      r_g85_p2  <= '0;
      r_b128_p2 <= '0;
      r_r128_p2 <= '0;
      r_g107_p2 <= '0;
      r_b21_p2  <= '0;
      r_thr_p3  <= '0;
      r_cb_p3   <= '0;
      r_cr_p3   <= '0;
      r_mask_p4 <= 1'b0;
    end else begin
      // stage 1: 565 -> 888
      r_thr_p1  <= {r_cb_min_s, r_cb_max_s, r_cr_min_s, r_cr_max_s};
      r_r8_p1   <= {pre_rgb565[15:11], pre_rgb565[15:13]};
      r_g8_p1   <= {pre_rgb565[10:5],  pre_rgb565[10:9]};
      r_b8_p1   <= {pre_rgb565[4:0],   pre_rgb565[4:2]};
      // stage 2: products
      r_thr_p2  <= r_thr_p1;
      r_r43_p2  <= 16'(r_r8_p1) * 16'd43;
      r_g85_p2  <= 16'(r_g8_p1) * 16'd85;
      r_b128_p2 <= {1'b0, r_b8_p1, 7'd0};
      r_r128_p2 <= {1'b0, r_r8_p1, 7'd0};
      r_g107_p2 <= 16'(r_g8_p1) * 16'd107;
      r_b21_p2  <= 16'(r_b8_p1) * 16'd21;
      // stage 3: sums stay within 128..65408, so modulo-2^16 arithmetic is exact
      r_thr_p3  <= r_thr_p2;
      r_cb_p3   <= 8'((16'd32768 - r_r43_p2 - r_g85_p2 + r_b128_p2) >> 8);
      r_cr_p3   <= 8'((16'd32768 + r_r128_p2 - r_g107_p2 - r_b21_p2) >> 8);
      // stage 4: window test
      r_mask_p4 <= r_ctl_sr[LATENCY-2][16]
                 & in_rng(r_cb_p3, r_thr_p3[31:24], r_thr_p3[23:16])
                 & in_rng(r_cr_p3, r_thr_p3[15:8],  r_thr_p3[7:0]);
    end
  end

  assign isp_href     = r_ctl_sr[LATENCY-1][18];
  assign isp_vsync    = r_ctl_sr[LATENCY-1][17];
  assign isp_wr_en    = r_ctl_sr[LATENCY-1][16];
  assign syn_data     = r_ctl_sr[LATENCY-1][15:0];
  assign isp_1bit_out = r_mask_p4;

`ifdef ISP_BIN_PIX_CNT_EN
  logic             r_vsync_d;
  logic             r_fg_vld;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_fg_count;
  logic             w_evt;
  logic             w_vsync_rise;

  assign w_evt        = isp_wr_en & isp_1bit_out;
  assign w_vsync_rise = isp_vsync & ~r_vsync_d;

  // An event on the vsync-edge cycle belongs to the new frame
  always_ff @(posedge vtc_clk or negedge vtc_rstn) begin
    if (!vtc_rstn) begin
      r_vsync_d  <= 1'b0;
      r_fg_vld   <= 1'b0;
      r_cnt      <= '0;
      r_fg_count <= '0;
    end else begin
      r_vsync_d <= isp_vsync;
      r_fg_vld  <= w_vsync_rise;
      if (w_vsync_rise) begin
        r_fg_count <= r_cnt;
        r_cnt      <= w_evt ? CNT_W'(1) : '0;
      end else if (w_evt && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign fg_count     = r_fg_count;
  assign fg_count_vld = r_fg_vld;
`else
  assign fg_count     = '0;
  assign fg_count_vld = 1'b0;
`endif

endmodule

// File: tb/tb_isp_ycbcr_binarize.sv
// Directed, table-driven bench for isp_ycbcr_binarize (mask, delay matching, shadowing, reset).
module tb_isp_ycbcr_binarize;
  localparam int CNT_W = 20;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             hs = 1'b0, vs = 1'b0, wr = 1'b0;
  logic [15:0]      rgb = '0;
  logic [7:0]       cbmin = '0, cbmax = '0, crmin = '0, crmax = '0;
  logic             href, vsync, wr_en, mask;
  logic [15:0]      syn;
  logic [CNT_W-1:0] fgc;
  logic             fgv;

  isp_ycbcr_binarize #(.LATENCY(4), .CNT_W(CNT_W)) dut (
    .vtc_clk(clk), .vtc_rstn(rstn),
    .pre_hs(hs), .pre_vs(vs), .pre_wr_en(wr), .pre_rgb565(rgb),
    .cb_min(cbmin), .cb_max(cbmax), .cr_min(crmin), .cr_max(crmax),
    .isp_href(href), .isp_vsync(vsync), .isp_wr_en(wr_en), .isp_1bit_out(mask),
    .syn_data(syn), .fg_count(fgc), .fg_count_vld(fgv)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        wr;
    logic [15:0] rgb;
    logic        exp;
  } vec_t;

  localparam logic [15:0] RED = 16'hF800, BLUE = 16'h001F, WHITE = 16'hFFFF,
                          BLACK = 16'h0000, SKIN = 16'hFE10, RED_B1 = 16'hF801;

  vec_t tbl[8];
  vec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic h, input logic v, input logic w,
                              input logic [15:0] p, input logic e);
    vec_t t;
    t.hs = h; t.vs = v; t.wr = w; t.rgb = p; t.exp = e;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic set_thr(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    cbmin = a; cbmax = b; crmin = c; crmax = d;
  endtask

  task automatic drive(input vec_t v);
    hs = v.hs; vs = v.vs; wr = v.wr; rgb = v.rgb;
  endtask

  // Streams q back-to-back; vector c is expected at the outputs exactly 4 edges later.
  task automatic run_q(input bit head_zero);
    int n;
    vec_t e;
    n = q.size();
    for (int c = 0; c < n + 4; c++) begin
      @(posedge clk); #1;
      if (c >= 4) begin
        e = q[c-4];
        chk("mask", c - 4, 32'(mask), 32'(e.exp));
        chk("syn_data", c - 4, 32'(syn), 32'(e.rgb));
        chk("ctrl", c - 4, 32'({href, vsync, wr_en}), 32'({e.hs, e.vs, e.wr}));
      end else if (head_zero) begin
        chk("flushed", c, 32'({href, vsync, wr_en, mask, syn}), 32'd0);
      end
      if (c < n) drive(q[c]);
      else       drive(mk(0, 0, 0, 16'h0, 0));
    end
    q.delete();
  endtask

  task automatic drive_px(input logic h, input logic v, input logic w, input logic [15:0] p);
    @(posedge clk); #1;
    hs = h; vs = v; wr = w; rgb = p;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nv;
    logic [CNT_W-1:0] cnt_at;

    // Red-pass vectors (cb 80..90, cr 250..255)
    tbl[0] = mk(0, 1, 0, BLACK,  0);
    tbl[1] = mk(1, 0, 1, RED,    1);
    tbl[2] = mk(1, 0, 1, BLUE,   0);
    tbl[3] = mk(1, 0, 0, RED,    0);
    tbl[4] = mk(0, 0, 1, WHITE,  0);
    tbl[5] = mk(1, 0, 1, BLACK,  0);
    tbl[6] = mk(1, 0, 1, RED_B1, 1);
    tbl[7] = mk(0, 0, 1, SKIN,   0);

    set_thr(8'd80, 8'd90, 8'd250, 8'd255);
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset", 0, 32'({href, vsync, wr_en, mask, syn}), 32'd0);
    rstn = 1'b1;

    // Defaults cb 77..127 / cr 133..173 apply until the first vsync edge
    q.push_back(mk(1, 0, 1, WHITE, 0));
    q.push_back(mk(1, 0, 1, SKIN,  1));
    q.push_back(mk(1, 0, 1, RED,   0));
    q.push_back(mk(0, 0, 1, BLACK, 0));
    q.push_back(mk(1, 0, 0, SKIN,  0));
    run_q(1);

    for (int i = 0; i < 8; i++) q.push_back(tbl[i]);
    run_q(0);

    // Mid-frame threshold change waits for the next frame
    set_thr(8'd0, 8'd10, 8'd0, 8'd10);
    q.push_back(mk(1, 0, 1, RED, 1));
    q.push_back(mk(1, 0, 1, RED, 1));
    run_q(0);
    q.push_back(mk(0, 1, 0, BLACK, 0));
    q.push_back(mk(1, 0, 1, RED,   0));
    q.push_back(mk(1, 0, 1, SKIN,  0));
    run_q(0);

    // Inclusive bounds and empty ranges
    set_thr(8'd85, 8'd85, 8'd255, 8'd255);
    q.push_back(mk(0, 1, 0, BLACK,  0));
    q.push_back(mk(1, 0, 1, RED,    1));
    q.push_back(mk(1, 0, 1, RED_B1, 0));
    run_q(0);
    set_thr(8'd86, 8'd90, 8'd250, 8'd255);
    q.push_back(mk(0, 1, 0, BLACK, 0));
    q.push_back(mk(1, 0, 1, RED,   0));
    run_q(0);
    set_thr(8'd90, 8'd80, 8'd255, 8'd250);
    q.push_back(mk(0, 1, 0, BLACK, 0));
    q.push_back(mk(1, 0, 1, RED,   0));
    q.push_back(mk(1, 0, 1, SKIN,  0));
    run_q(0);

    // Pixel coincident with the vsync edge uses the old thresholds
    set_thr(8'd80, 8'd90, 8'd250, 8'd255);
    q.push_back(mk(0, 1, 0, BLACK, 0));
    q.push_back(mk(1, 0, 1, RED,   1));
    run_q(0);
    set_thr(8'd0, 8'd10, 8'd0, 8'd10);
    q.push_back(mk(1, 1, 1, RED, 1));
    q.push_back(mk(1, 0, 1, RED, 0));
    run_q(0);

    // Asynchronous reset mid-line
    set_thr(8'd80, 8'd90, 8'd250, 8'd255);
    q.push_back(mk(0, 1, 0, BLACK, 0));
    run_q(0);
    hs = 1'b1; wr = 1'b1; rgb = WHITE;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_syn", 0, 32'(syn), 32'(WHITE));
    chk("pre_rst_ctrl", 0, 32'({href, wr_en}), 32'b11);
    #3 rstn = 1'b0;
    #1;
    chk("rst_async", 0, 32'({href, vsync, wr_en, mask, syn}), 32'd0);
    chk("rst_cnt", 0, 32'({fgv, fgc}), 32'd0);
    hs = 1'b0; wr = 1'b0; rgb = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    q.push_back(mk(1, 0, 1, SKIN, 1));
    q.push_back(mk(1, 0, 1, RED,  0));
    run_q(1);

`ifdef ISP_BIN_PIX_CNT_EN
    set_thr(8'd80, 8'd90, 8'd250, 8'd255);
    drive_px(0, 1, 0, 16'h0);
    for (int i = 0; i < 2000; i++) drive_px(1, 0, 1, (i % 2 == 0) ? RED : WHITE);
    repeat (8) drive_px(0, 0, 0, 16'h0);
    drive_px(0, 1, 0, 16'h0);
    drive_px(0, 0, 0, 16'h0);
    nv = 0;
    cnt_at = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (fgv) begin
        nv++;
        cnt_at = fgc;
      end
    end
    chk("fg_vld_cycles", 0, 32'(nv), 32'd1);
    chk("fg_count", 0, 32'(cnt_at), 32'd1000);
`else
    nv = 0;
    cnt_at = '0;
    drive_px(0, 1, 0, 16'h0);
    for (int i = 0; i < 12; i++) begin
      drive_px(1, 0, 1, RED);
      if (fgv || (fgc != '0)) nv++;
    end
    chk("fg_tie_off", 0, 32'(nv), 32'd0);
    chk("fg_count_tie", 0, 32'({fgv, fgc}), 32'(cnt_at));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/isp_ycbcr_binarize.md
Name: isp_ycbcr_binarize

Overview:
- Upstream pixel stage feeding obj_check_and_boundary.
- Converts a synchronised RGB565 stream to YCbCr and thresholds Cb/Cr into a 1-bit foreground mask (isp_1bit_out).
- Forwards href/vsync/wr_en and the original RGB565 (syn_data), all delay-matched, so the downstream object-check and boundary-fusion stages receive aligned mask and camera data.
- Thresholds are runtime inputs, frame-synchronously shadowed.

Parameters:
- LATENCY, 4, fixed pipeline depth in cycles; documentation only, must not be overridden.
- CNT_W, 20, width of the optional foreground counter (covers 960x540 = 518400).

Ports:
- vtc_clk  in  1  pixel clock
- vtc_rstn  in  1  asynchronous active-low reset
- pre_hs  in  1  input line valid
- pre_vs  in  1  input frame sync, active high; rising edge = frame start
- pre_wr_en  in  1  input pixel valid
- pre_rgb565  in  16  input pixel {R5,G6,B5}
- cb_min  in  8  Cb lower bound, inclusive
- cb_max  in  8  Cb upper bound, inclusive
- cr_min  in  8  Cr lower bound, inclusive
- cr_max  in  8  Cr upper bound, inclusive
- isp_href  out  1  pre_hs delayed 4 cycles
- isp_vsync  out  1  pre_vs delayed 4 cycles
- isp_wr_en  out  1  pre_wr_en delayed 4 cycles
- isp_1bit_out  out  1  foreground mask
- syn_data  out  16  pre_rgb565 delayed 4 cycles
- fg_count  out  CNT_W  previous-frame foreground pixel count (PIX_CNT_EN only)
- fg_count_vld  out  1  one-cycle pulse when fg_count updates (PIX_CNT_EN only)

Behaviour:
- Reset is asynchronous. All outputs and all pipeline and shadow registers clear to 0, except the shadows, which load their defaults: cb 77..127, cr 133..173.
- Stage 1: expand 565 to 888.
  - R8 = {R5, R5[4:2]}
  - G8 = {G6, G6[5:4]}
  - B8 = {B5, B5[4:2]}
- Stage 2: register the products 43R, 85G, 128B (shift), 107G, 21B.
- Stage 3: form both sums as 16-bit unsigned values. The range is provably 128..65408, so no clamping is needed.
  - cb_sum = 32768 - 43R - 85G + 128B
  - cr_sum = 32768 + 128R - 107G - 21B
  - Cb = cb_sum[15:8]
  - Cr = cr_sum[15:8]
  - Y is not computed.
- Stage 4 output: isp_1bit_out = wr_en_d3 & (cb_min_s <= Cb <= cb_max_s) & (cr_min_s <= Cr <= cr_max_s).
  - Pixels with wr_en low always output 0.
- Control signals and syn_data pass through matching 4-stage shift registers. Latency is exactly 4 cycles, independent of wr_en gaps; there is no backpressure.
- Threshold shadowing: the four *_s registers load cb_min..cr_max in the cycle after a rising edge of pre_vs, and hold for the rest of the frame. Mid-frame input changes have no effect until the next frame.
- min > max on either axis yields an empty range: all mask output is 0, with no error flag.
- Reset asserted mid-frame flushes the pipeline. After release:
  - Outputs stay 0 until new input propagates (4 cycles).
  - Shadows hold their defaults until the next pre_vs rising edge.
- pre_vs rising on the same cycle as pre_wr_en is legal. That pixel uses the old shadow values.

Optional Feature:
- Macro: ISP_BIN_PIX_CNT_EN.
- When defined:
  - A CNT_W-bit counter increments on each output cycle with isp_wr_en & isp_1bit_out, saturating at all-ones.
  - On an isp_vsync rising edge, fg_count latches the counter, fg_count_vld pulses for 1 cycle, and the counter restarts at 0.
  - A count event on the same cycle as the vsync edge is counted into the new frame.
  - Reset clears fg_count, the counter and fg_count_vld.
- When undefined: fg_count ties to 0, fg_count_vld ties to 0, and no counter logic is instantiated.

Test Plan:
- Reset defaults, drive 0xFFFF (white), wr_en=1 -> Cb=128 and Cr=128 reach stage 4; isp_1bit_out=0 (Cr 128 < 133); syn_data=0xFFFF exactly 4 cycles after input.
- Set thresholds cb 80..90, cr 250..255, pulse pre_vs, then drive 0xF800 (red) -> Cb=85, Cr=255, isp_1bit_out=1 at +4 cycles; 0x001F (blue: Cb=255, Cr=107) -> 0.
- Same red pixel with pre_wr_en=0 -> isp_1bit_out=0; isp_href/isp_vsync/isp_wr_en match the inputs delayed 4 cycles.
- Change thresholds mid-frame to exclude red -> mask stays 1 until after the next pre_vs rising edge, then 0.
- Assert vtc_rstn low mid-line -> all outputs 0 immediately (async), shadows back to 77..127/133..173.
- ISP_BIN_PIX_CNT_EN defined, frame with 1000 red pixels out of 2000 valid (red-pass thresholds) -> at next isp_vsync edge fg_count=1000, fg_count_vld high exactly 1 cycle.
